sync_fifo: RTL and testbench

//  Single-clock FIFO, successor to the ripple/gray-pointer fifo. Fully

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_if.sv | 27 ++
 rtl/fifo_ram.sv | 20 ++
 rtl/sync_fifo.sv | 115 +++++++++++
 tb/tb_sync_fifo.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared fifo mode constants and depth helpers
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_depth(input int order);
    return 1 << order;
  endfunction

  function automatic int fifo_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - producer/consumer side signals of sync_fifo
interface sync_fifo_if #(
  parameter int W     = 8,
  parameter int ORDER = 4
);
  logic [W-1:0] in;
  logic         put;
  logic         full;
  logic         almost_full;
  logic [W-1:0] out;
  logic         get;
  logic         empty;
  logic         almost_empty;
  logic [ORDER:0] count;
  logic         overflow;
  logic         underflow;

  modport master (
    output in, put, get,
    input  full, almost_full, out, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  in, put, get,
    output full, almost_full, out, empty, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port storage, sync write, async read
module fifo_ram #(
  parameter int W     = 8,
  parameter int ORDER = 4
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [ORDER-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [ORDER-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);
  logic [W-1:0] r_mem [0:(1<<ORDER)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock fifo with count, almost flags, optional FWFT
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int ORDER = 4,
  parameter int AF    = 14,
  parameter int AE    = 2,
  parameter int FWFT  = FIFO_MODE_STD
) (
  input  logic       clock,
  input  logic       reset_n,
  sync_fifo_if.slave bus
);
  localparam int             DEPTH   = fifo_depth(ORDER);
  localparam logic [ORDER:0] DEPTH_C = DEPTH[ORDER:0];
  localparam logic [ORDER:0] AF_C    = AF[ORDER:0];
  localparam logic [ORDER:0] AE_C    = AE[ORDER:0];
  localparam bit             IS_FWFT = (FWFT == FIFO_MODE_FWFT);

  logic [ORDER-1:0] r_wptr;
  logic [ORDER-1:0] r_rptr;
  logic [ORDER:0]   r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_almost_full;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;
  logic [W-1:0]     r_out;

  logic             w_wr_en;
  logic             w_rd_en;
  logic [ORDER-1:0] w_rptr_inc;
  logic [ORDER-1:0] w_ram_raddr;
  logic [W-1:0]     w_ram_rdata;
  logic [ORDER:0]   w_count_nxt;
  logic [W-1:0]     w_out_nxt;

  assign w_wr_en     = bus.put & ~r_full;
  assign w_rd_en     = bus.get & ~r_empty;
  assign w_rptr_inc  = r_rptr + 1'b1;
  // FWFT looks one slot ahead: the word that becomes head after a get.
  assign w_ram_raddr = IS_FWFT ? w_rptr_inc : r_rptr;

  fifo_ram #(
    .W     (W),
    .ORDER (ORDER)
  ) u_ram (
    .i_clk   (clock),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr),
    .i_wdata (bus.in),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_en && !w_rd_en)
      w_count_nxt = r_count + 1'b1;
    else if (!w_wr_en && w_rd_en)
      w_count_nxt = r_count - 1'b1;
  end

  always_comb begin
    w_out_nxt = r_out;
    if (IS_FWFT) begin
      if (w_rd_en) begin
        // New head may be the word written on this same edge, not yet in ram.
        if (w_count_nxt != '0)
          w_out_nxt = (w_wr_en && (r_wptr == w_rptr_inc)) ? bus.in : w_ram_rdata;
      end else if (r_empty && w_wr_en) begin
        w_out_nxt = bus.in;
      end
    end else if (w_rd_en) begin
      w_out_nxt = w_ram_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= (AF_C == '0);
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
      r_out          <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= w_rptr_inc;
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == DEPTH_C);
      r_empty        <= (w_count_nxt == '0);
      r_almost_full  <= (w_count_nxt >= AF_C);
      r_almost_empty <= (w_count_nxt <= AE_C);
      r_out          <= w_out_nxt;
      if (bus.put && r_full)  r_overflow  <= 1'b1;
      if (bus.get && r_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.full         = r_full;
  assign bus.almost_full  = r_almost_full;
  assign bus.out          = r_out;
  assign bus.empty        = r_empty;
  assign bus.almost_empty = r_almost_empty;
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - standard and FWFT fifos driven in lockstep against a queue model
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int W     = 8;
  localparam int ORDER = 2;
  localparam int CAP   = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic clock;
  logic reset_n;

  sync_fifo_if #(.W(W), .ORDER(ORDER)) bus_s ();
  sync_fifo_if #(.W(W), .ORDER(ORDER)) bus_f ();

  sync_fifo #(.W(W), .ORDER(ORDER), .AF(AF), .AE(AE), .FWFT(FIFO_MODE_STD)) u_std (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_s)
  );

  sync_fifo #(.W(W), .ORDER(ORDER), .AF(AF), .AE(AE), .FWFT(FIFO_MODE_FWFT)) u_fwft (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_f)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp;
  int n_err;

  logic [W-1:0] q[$];
  logic [W-1:0] m_out_std;
  logic [W-1:0] m_out_fwft;
  bit           m_ovf;
  bit           m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_out_std  = '0;
    m_out_fwft = '0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock edge as the fifo rules describe it: reads see the pre-edge contents.
  task automatic model_edge(input bit p, input bit g, input logic [W-1:0] d);
    bit was_full;
    bit was_empty;
    was_full  = (q.size() == CAP);
    was_empty = (q.size() == 0);
    if (p && was_full)  m_ovf = 1'b1;
    if (g && was_empty) m_udf = 1'b1;
    if (g && !was_empty) begin
      m_out_std = q[0];
      void'(q.pop_front());
    end
    if (p && !was_full) q.push_back(d);
    if (q.size() != 0) m_out_fwft = q[0];
  endtask

  task automatic check_all(input string where);
    int n;
    n = q.size();
    chk({where, " std.count"},  32'(bus_s.count),      32'(n));
    chk({where, " fwft.count"}, 32'(bus_f.count),      32'(n));
    chk({where, " std.empty"},  32'(bus_s.empty),      32'(n == 0));
    chk({where, " fwft.empty"}, 32'(bus_f.empty),      32'(n == 0));
    chk({where, " std.full"},   32'(bus_s.full),       32'(n == CAP));
    chk({where, " fwft.full"},  32'(bus_f.full),       32'(n == CAP));
    chk({where, " std.af"},     32'(bus_s.almost_full),  32'(n >= AF));
    chk({where, " fwft.af"},    32'(bus_f.almost_full),  32'(n >= AF));
    chk({where, " std.ae"},     32'(bus_s.almost_empty), 32'(n <= AE));
    chk({where, " fwft.ae"},    32'(bus_f.almost_empty), 32'(n <= AE));
    chk({where, " std.ovf"},    32'(bus_s.overflow),   32'(m_ovf));
    chk({where, " fwft.ovf"},   32'(bus_f.overflow),   32'(m_ovf));
    chk({where, " std.udf"},    32'(bus_s.underflow),  32'(m_udf));
    chk({where, " fwft.udf"},   32'(bus_f.underflow),  32'(m_udf));
    chk({where, " std.out"},    32'(bus_s.out),        32'(m_out_std));
    chk({where, " fwft.out"},   32'(bus_f.out),        32'(m_out_fwft));
  endtask

  task automatic drive(input bit p, input bit g, input logic [W-1:0] d);
    bus_s.put = p;  bus_f.put = p;
    bus_s.get = g;  bus_f.get = g;
    bus_s.in  = d;  bus_f.in  = d;
  endtask

  task automatic cycle(input string where, input bit p, input bit g, input logic [W-1:0] d);
    drive(p, g, d);
    @(posedge clock);
    model_edge(p, g, d);
    #1;
    check_all(where);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset(input string where);
    drive(1'b0, 1'b0, '0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all(where);
    #1;
    reset_n = 1'b1;
  endtask

  int pbias;
  int gbias;

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, '0);
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    cycle("idle", 1'b0, 1'b0, '0);

    for (int i = 0; i < 5; i++)
      cycle($sformatf("fill%0d", i), 1'b1, 1'b0, 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 5; i++)
      cycle($sformatf("drain%0d", i), 1'b0, 1'b1, '0);

    async_reset("rst2");
    cycle("pre0", 1'b1, 1'b0, 8'hB1);
    cycle("pre1", 1'b1, 1'b0, 8'hB2);
    for (int i = 0; i < 8; i++)
      cycle($sformatf("pg%0d", i), 1'b1, 1'b1, 8'(8'hC0 + i));

    cycle("top0", 1'b1, 1'b0, 8'hD1);
    cycle("top1", 1'b1, 1'b0, 8'hD2);
    cycle("fullpg", 1'b1, 1'b1, 8'hD3);

    async_reset("midrst");
    cycle("a5put", 1'b1, 1'b0, 8'hA5);
    cycle("a5get", 1'b0, 1'b1, '0);

    pbias = 50;
    gbias = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        pbias = $urandom_range(20, 90);
        gbias = $urandom_range(20, 90);
      end
      if (i == 300) async_reset("rndrst");
      cycle($sformatf("rnd%0d", i),
            ($urandom_range(0, 99) < pbias),
            ($urandom_range(0, 99) < gbias),
            8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
